// File: rtl/sp_mac.sv
// sp_mac: spline-basis multiply-accumulate for one KAN neuron.
// Three-stage pipeline: S1 multiplies four basis/coefficient pairs,
// S2 adds the four products and rescales to Q7.10, and S3 accumulates
// P_NUM_IN samples into one neuron sum.
// Optional build macro: SP_MAC_SAT_EN -- when defined, the output sum is
// saturated to the signed 18-bit range instead of wrapping.
// P_ACC_W is expected to be at least 18 so the output slice exists.
module sp_mac #(
    parameter int P_NUM_IN = 8,
    parameter int P_ACC_W  = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_valid,
    input  logic [9:0]  i_data_1,
    input  logic [9:0]  i_data_2,
    input  logic [9:0]  i_data_3,
    input  logic [9:0]  i_data_4,
    input  logic [17:0] i_coef_1,
    input  logic [17:0] i_coef_2,
    input  logic [17:0] i_coef_3,
    input  logic [17:0] i_coef_4,
    output logic        o_valid,
    output logic [17:0] o_sum
);

    // The counter only needs to reach 254, so eight bits always suffice.
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(P_NUM_IN - 1);

    // Saturation bounds of the signed Q7.10 output, at accumulator width.
    localparam logic signed [P_ACC_W-1:0] SAT_MAX = P_ACC_W'(131071);
    localparam logic signed [P_ACC_W-1:0] SAT_MIN = P_ACC_W'(-131072);

    // Operands widened to the 29-bit product width.
    // Basis values are unsigned and therefore zero-extended.
    logic signed [28:0] data_ext [4];
    logic signed [28:0] coef_ext [4];

    // S1 registers: the four Q7.20 products.
    logic               s1_valid;
    logic signed [28:0] prod [4];

    // S2 registers: the rescaled per-sample sum.
    logic               s2_valid;
    logic signed [30:0] prod_sum;
    logic signed [30:0] prod_sum_shr;
    logic signed [P_ACC_W-1:0] s2_val;

    // S3 registers: accumulator, sample counter and the output.
    logic signed [P_ACC_W-1:0] acc;
    logic signed [P_ACC_W-1:0] acc_next;
    logic [CNT_W-1:0]          cnt;
    logic                      group_last;
    logic [17:0]               sum_out;
    logic                      out_valid_q;

    // Widen the separate input ports into indexable operand arrays.
    always_comb begin
        data_ext[0] = {19'b0, i_data_1};
        data_ext[1] = {19'b0, i_data_2};
        data_ext[2] = {19'b0, i_data_3};
        data_ext[3] = {19'b0, i_data_4};
        coef_ext[0] = {{11{i_coef_1[17]}}, i_coef_1};
        coef_ext[1] = {{11{i_coef_2[17]}}, i_coef_2};
        coef_ext[2] = {{11{i_coef_3[17]}}, i_coef_3};
        coef_ext[3] = {{11{i_coef_4[17]}}, i_coef_4};
    end

    // S1: register the four products; the registers stay put on bubbles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                prod[k] <= '0;
            end
        end else if (i_en) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                for (int k = 0; k < 4; k++) begin
                    prod[k] <= coef_ext[k] * data_ext[k];
                end
            end
        end
    end

    // Sum the products with two guard bits, then drop ten fraction bits.
    // The arithmetic shift of a two's-complement value rounds toward
    // minus infinity, which is the rounding this neuron needs.
    always_comb begin
        prod_sum = 31'(prod[0]) + 31'(prod[1]) + 31'(prod[2]) + 31'(prod[3]);
        prod_sum_shr = prod_sum >>> 10;
    end

    // S2: register the rescaled sample, sign-extended to accumulator width.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_val   <= '0;
        end else if (i_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_val <= P_ACC_W'(prod_sum_shr);
            end
        end
    end

    // The first sample of a group loads the accumulator rather than
    // adding, so no separate clear cycle is needed between groups.
    always_comb begin
        acc_next   = (cnt == '0) ? s2_val : acc + s2_val;
        group_last = (cnt == LAST_CNT);
    end

    // Reduce the final accumulator to the 18-bit output format.
`ifdef SP_MAC_SAT_EN
    always_comb begin
        sum_out = acc_next[17:0];
        if (acc_next > SAT_MAX) begin
            sum_out = SAT_MAX[17:0];
        end else if (acc_next < SAT_MIN) begin
            sum_out = SAT_MIN[17:0];
        end
    end
`else
    always_comb begin
        sum_out = acc_next[17:0];
    end
`endif

    // S3: accumulate, count samples and publish the sum when a group closes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            o_sum       <= '0;
        end else if (i_en) begin
            out_valid_q <= 1'b0;
            if (s2_valid) begin
                acc <= acc_next;
                if (group_last) begin
                    cnt         <= '0;
                    out_valid_q <= 1'b1;
                    o_sum       <= sum_out;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // A pulse that became due while stalled is held in out_valid_q and
    // is masked until the pipeline is enabled again.
    assign o_valid = out_valid_q & i_en;

endmodule

// File: tb/tb_sp_mac.sv
// tb_sp_mac: self-checking bench for sp_mac.
// Three instances (fan-in 1, 4 and 8) share one stimulus stream and are
// each compared every cycle against a group-level reference model.
// Honours SP_MAC_SAT_EN in the same way as the design.
module tb_sp_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vld;
    logic [9:0]  d1, d2, d3, d4;
    logic [17:0] c1, c2, c3, c4;
    logic        dut_valid [3];
    logic [17:0] dut_sum [3];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int due;
        int val;
    } pend_t;

    int      num_in [3] = '{1, 4, 8};
    pend_t   pq [3][$];
    int      grp_cnt [3];
    longint  grp_sum [3];
    int      osum_exp [3];
    int      en_cycles = 0;
    bit      model_on = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    sp_mac #(.P_NUM_IN(1), .P_ACC_W(32)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(vld),
        .i_data_1(d1), .i_data_2(d2), .i_data_3(d3), .i_data_4(d4),
        .i_coef_1(c1), .i_coef_2(c2), .i_coef_3(c3), .i_coef_4(c4),
        .o_valid(dut_valid[0]), .o_sum(dut_sum[0])
    );

    sp_mac #(.P_NUM_IN(4), .P_ACC_W(32)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(vld),
        .i_data_1(d1), .i_data_2(d2), .i_data_3(d3), .i_data_4(d4),
        .i_coef_1(c1), .i_coef_2(c2), .i_coef_3(c3), .i_coef_4(c4),
        .o_valid(dut_valid[1]), .o_sum(dut_sum[1])
    );

    sp_mac #(.P_NUM_IN(8), .P_ACC_W(32)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(vld),
        .i_data_1(d1), .i_data_2(d2), .i_data_3(d3), .i_data_4(d4),
        .i_coef_1(c1), .i_coef_2(c2), .i_coef_3(c3), .i_coef_4(c4),
        .o_valid(dut_valid[1+1]), .o_sum(dut_sum[1+1])
    );

    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Exact value of one sample: floor(sum(coef*data) / 1024).
    function automatic int sampleValue(input logic [9:0] a1, a2, a3, a4,
                                       input logic [17:0] b1, b2, b3, b4);
        longint tot;
        longint q;
        tot = longint'($signed(b1)) * longint'(a1) + longint'($signed(b2)) * longint'(a2)
            + longint'($signed(b3)) * longint'(a3) + longint'($signed(b4)) * longint'(a4);
        q = tot / 1024;
        if (tot < 0 && q * 1024 != tot) q = q - 1;
        return int'(q);
    endfunction

    // Group total wrapped to the 32-bit accumulator, then reduced to 18 bits.
    function automatic int groupResult(input longint total);
        int acc32;
        int w;
        acc32 = int'(total);
`ifdef SP_MAC_SAT_EN
        if (acc32 > 131071) w = 131071;
        else if (acc32 < -131072) w = -131072;
        else w = acc32;
`else
        w = acc32 & 32'h3FFFF;
        if (w > 131071) w = w - 262144;
`endif
        return w;
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic v,
                                 input logic [9:0] a1, a2, a3, a4,
                                 input logic [17:0] b1, b2, b3, b4);
        bit ev;
        int s;
        pend_t p;
        @(posedge clk);
        #1;
        rst = r; en = e; vld = v;
        d1 = a1; d2 = a2; d3 = a3; d4 = a4;
        c1 = b1; c2 = b2; c3 = b3; c4 = b4;
        @(negedge clk);
        if (model_on) begin
            for (int i = 0; i < 3; i++) begin
                ev = e && (pq[i].size() > 0) && (pq[i][0].due == en_cycles);
                checkOutput($sformatf("o_valid[N=%0d]", num_in[i]), int'(dut_valid[i]), int'(ev));
                checkOutput($sformatf("o_sum[N=%0d]", num_in[i]), int'($signed(dut_sum[i])), osum_exp[i]);
                if (ev) void'(pq[i].pop_front());
            end
        end
        if (r) begin
            model_on = 1'b1;
            for (int i = 0; i < 3; i++) begin
                pq[i].delete();
                grp_cnt[i] = 0;
                grp_sum[i] = 0;
                osum_exp[i] = 0;
            end
        end else if (e) begin
            if (v) begin
                s = sampleValue(a1, a2, a3, a4, b1, b2, b3, b4);
                for (int i = 0; i < 3; i++) begin
                    if (grp_cnt[i] == 0) grp_sum[i] = s;
                    else grp_sum[i] = grp_sum[i] + s;
                    grp_cnt[i]++;
                    if (grp_cnt[i] == num_in[i]) begin
                        p.due = en_cycles + 3;
                        p.val = groupResult(grp_sum[i]);
                        pq[i].push_back(p);
                        grp_cnt[i] = 0;
                    end
                end
            end
            en_cycles++;
            for (int i = 0; i < 3; i++) begin
                if (pq[i].size() > 0 && pq[i][0].due == en_cycles) osum_exp[i] = pq[i][0].val;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Sample worth exactly 1024: 512 * 2048 / 1024.
    task automatic sample1024();
        applyStimulus(1'b0, 1'b1, 1'b1, 10'd512, 0, 0, 0, 18'd2048, 0, 0, 0);
    endtask

    task automatic sampleZero();
        applyStimulus(1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0;
        d1 = 0; d2 = 0; d3 = 0; d4 = 0;
        c1 = 0; c2 = 0; c3 = 0; c4 = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        doReset();

        // Fan-in 1, two weighted terms.
        applyStimulus(1'b0, 1'b1, 1'b1, 10'd512, 10'd512, 0, 0, 18'd1024, 18'd2048, 0, 0);
        idle(2);
        checkOutput("req26_not_early", int'(dut_valid[0]), 0);
        idle(1);
        checkOutput("req26_valid", int'(dut_valid[0]), 1);
        checkOutput("req26_sum", int'($signed(dut_sum[0])), 1536);

        // Reset while a sample is offered.
        applyStimulus(1'b1, 1'b1, 1'b1, 10'd512, 10'd512, 0, 0, 18'd1024, 18'd2048, 0, 0);
        idle(1);
        checkOutput("req25_valid", int'(dut_valid[0]), 0);
        checkOutput("req25_sum", int'($signed(dut_sum[0])), 0);

        // Floor rounding of a tiny negative product.
        applyStimulus(1'b0, 1'b1, 1'b1, 10'd1, 0, 0, 0, 18'h3FFFF, 0, 0, 0);
        idle(3);
        checkOutput("req28_valid", int'(dut_valid[0]), 1);
        checkOutput("req28_sum", int'($signed(dut_sum[0])), -1);

        // Back-to-back groups at fan-in 4; the next group must load.
        doReset();
        for (int k = 0; k < 4; k++) sample1024();
        sample1024();
        sampleZero();
        sampleZero();
        checkOutput("req27_valid", int'(dut_valid[1]), 1);
        checkOutput("req27_sum", int'($signed(dut_sum[1])), 4096);
        sampleZero();
        idle(3);
        checkOutput("req27_load_valid", int'(dut_valid[1]), 1);
        checkOutput("req27_load_sum", int'($signed(dut_sum[1])), 1024);

        // Full-scale inputs at fan-in 8.
        doReset();
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b0, 1'b1, 1'b1, 10'd1023, 10'd1023, 10'd1023, 10'd1023,
                          18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF);
        idle(3);
        checkOutput("req29_valid", int'(dut_valid[1+1]), 1);
`ifdef SP_MAC_SAT_EN
        checkOutput("req29_sum", int'($signed(dut_sum[1+1])), 131071);
`else
        checkOutput("req29_sum", int'($signed(dut_sum[1+1])), -4128);
`endif

        // Two-cycle stall in mid-group at fan-in 4.
        doReset();
        sample1024();
        sample1024();
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd512, 0, 0, 0, 18'd2048, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd512, 0, 0, 0, 18'd2048, 0, 0, 0);
        sample1024();
        sample1024();
        idle(1);
        checkOutput("req30_stall_early1", int'(dut_valid[1]), 0);
        idle(1);
        checkOutput("req30_stall_early2", int'(dut_valid[1]), 0);
        idle(1);
        checkOutput("req30_stall_valid", int'(dut_valid[1]), 1);
        checkOutput("req30_stall_sum", int'($signed(dut_sum[1])), 4096);

        // Reset after two samples discards the partial group.
        doReset();
        sample1024();
        sample1024();
        doReset();
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b0, 1'b1, 1'b1, 10'd256, 0, 0, 0, 18'd2048, 0, 0, 0);
        idle(2);
        checkOutput("req30_rst_early", int'(dut_valid[1]), 0);
        idle(1);
        checkOutput("req30_rst_valid", int'(dut_valid[1]), 1);
        checkOutput("req30_rst_sum", int'($signed(dut_sum[1])), 2048);

        // Randomized traffic with stalls, bubbles, resets and extreme values.
        for (int k = 0; k < 3000; k++) begin
            logic r, e, v;
            logic [9:0] a [4];
            logic [17:0] b [4];
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 4; j++) begin
                a[j] = 10'($urandom);
                b[j] = 18'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    a[j] = 10'd1023;
                    b[j] = $urandom_range(0, 1) ? 18'h1FFFF : 18'h20000;
                end
            end
            applyStimulus(r, e, v, a[0], a[1], a[2], a[3], b[0], b[1], b[2], b[3]);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
